// File: rtl/led_down_counter.sv
// Loadable down-counter driving the LED bank: decrements once every DIV clocks while enabled, flags done at zero.
// Optional blink-on-done behaviour is enabled by defining LED_DOWN_COUNTER_BLINK_EN.
module led_down_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 25_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] leds,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [31:0]      PRE_LAST = 32'(DIV - 1);
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [31:0]      pre_q, pre_d;
  logic [WIDTH-1:0] leds_q, leds_d;
  logic             done_q, done_d;
  logic             tick_s;
`ifdef LED_DOWN_COUNTER_BLINK_EN
  logic             phase_q, phase_d;
`endif

  assign tick_s = (pre_q == PRE_LAST);

  // Next-state logic: load overrides everything, then per-state behaviour.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pre_d   = pre_q;
`ifdef LED_DOWN_COUNTER_BLINK_EN
    phase_d = phase_q;
`endif
    if (load) begin
      count_d = load_val;
      pre_d   = 32'd0;
`ifdef LED_DOWN_COUNTER_BLINK_EN
      phase_d = 1'b0;
`endif
      if (load_val == {WIDTH{1'b0}}) begin
        state_d = ST_DONE;
      end else if (en) begin
        state_d = ST_RUN;
      end else begin
        state_d = ST_PAUSE;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_RUN: begin
          // Dropping en freezes pre where it is so the tick phase survives the pause.
          if (!en) begin
            state_d = ST_PAUSE;
          end else if (tick_s) begin
            pre_d   = 32'd0;
            count_d = count_q - CNT_ONE;
            if (count_q == CNT_ONE) begin
              state_d = ST_DONE;
`ifdef LED_DOWN_COUNTER_BLINK_EN
              phase_d = 1'b1;
`endif
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            pre_d = pre_q + 32'd1;
          end
        end
        ST_PAUSE: begin
          if (en) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_PAUSE;
          end
        end
        ST_DONE: begin
          count_d = {WIDTH{1'b0}};
`ifdef LED_DOWN_COUNTER_BLINK_EN
          if (tick_s) begin
            pre_d   = 32'd0;
            phase_d = ~phase_q;
          end else begin
            pre_d = pre_q + 32'd1;
          end
`else
          pre_d = 32'd0;
`endif
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Output values derived from next state so leds/done land on the same edge as count.
  always_comb begin
    done_d = (state_d == ST_DONE);
    if (done_d) begin
`ifdef LED_DOWN_COUNTER_BLINK_EN
      leds_d = {WIDTH{phase_d}};
`else
      leds_d = {WIDTH{1'b0}};
`endif
    end else begin
      leds_d = count_d;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= {WIDTH{1'b0}};
      pre_q   <= 32'd0;
      leds_q  <= {WIDTH{1'b0}};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pre_q   <= pre_d;
      leds_q  <= leds_d;
      done_q  <= done_d;
    end
  end

`ifdef LED_DOWN_COUNTER_BLINK_EN
  // Blink phase register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
    end
  end
`endif

  assign leds = leds_q;
  assign done = done_q;

endmodule
